// File: rtl/dmem_responder.sv
// Data-memory responder: decodes core load/store requests against the data segment and
// serves them from a byte-enabled word RAM. Define MMIO_LED_EN to map a 10-bit LED register at LED_ADDR.
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] LED_ADDR   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wren,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [9:0]  led_out,
  output logic [1:0]  state_dbg
);

  localparam int         DEPTH = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

`ifdef MMIO_LED_EN
  localparam logic LED_EN = 1'b1;
`else
  localparam logic LED_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                state;
  logic [31:0]           mem [DEPTH];
  logic [31:0]           off;
  logic                  in_range;
  logic                  misaligned;
  logic                  led_hit;
  logic                  req_err;
  logic                  accept;
  logic [DEPTH_LOG2-1:0] idx;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  wren_q;
  logic                  err_q;
  logic                  led_q;
  logic [9:0]            led_reg;

  // Handshakes: a transfer happens on a rising edge where valid && ready; the sender holds
  // valid and payload stable until then, and ready never depends on valid.
  assign off        = req_addr - BASE_ADDR;
  assign in_range   = {1'b0, off} < SPAN;
  assign misaligned = |req_addr[1:0];
  assign led_hit    = LED_EN && !misaligned && (req_addr == LED_ADDR);
  assign req_err    = !led_hit && (misaligned || !in_range);
  assign idx        = off[DEPTH_LOG2+1:2];
  assign req_ready  = (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign state_dbg  = state;
  assign led_out    = led_reg;

  // Stores commit at the accept edge so a following load always observes them.
  always_ff @(posedge clk) begin
    if (accept && req_wren && !req_err && !led_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      led_reg    <= '0;
      idx_q      <= '0;
      wren_q     <= 1'b0;
      err_q      <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            idx_q  <= idx;
            wren_q <= req_wren;
            err_q  <= req_err;
            led_q  <= led_hit;
            if (req_wren && led_hit) begin
              if (req_be[0]) led_reg[7:0] <= req_wdata[7:0];
              if (req_be[1]) led_reg[9:8] <= req_wdata[9:8];
            end
            state <= ACCESS;
          end
        end
        ACCESS: begin
          resp_valid <= 1'b1;
          resp_err   <= err_q;
          if (err_q || wren_q)  resp_rdata <= '0;
          else if (led_q)       resp_rdata <= {22'b0, led_reg};
          else                  resp_rdata <= mem[idx_q];
          state <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: table-driven request vectors, backpressure,
// reset mid-response, LED mapping (MMIO_LED_EN aware) and a randomized load/store mix.
module tb_dmem_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wren = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  led_out;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wren   (req_wren),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .led_out    (led_out),
    .state_dbg  (state_dbg)
  );

  typedef struct {
    logic        wren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic [32:0] exp_q[$];
  vec_t        vecs[$];
  logic [31:0] model[8];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic add_vec(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input logic [31:0] er, input logic ee);
    vec_t v;
    v.wren = w; v.addr = a; v.wdata = d; v.be = b; v.exp_rdata = er; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  task automatic clear_req();
    req_valid = 1'b0; req_wren = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
  endtask

  // One full transaction; optional stall cycles in RESP, optional ignored request pulse.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, input logic [31:0] er, input logic ee,
                        input int stall, input bit poke);
    logic [32:0] held;
    logic [32:0] want;
    @(negedge clk);
    check("req_ready_idle", 33'(req_ready), 33'd1);
    req_valid = 1'b1; req_wren = w; req_addr = a; req_wdata = d; req_be = b;
    exp_q.push_back({ee, er});
    @(posedge clk); #1;
    clear_req();
    @(negedge clk);
    check("latency_access_no_valid", 33'(resp_valid), 33'd0);
    @(negedge clk);
    check("latency_resp_valid", 33'(resp_valid), 33'd1);
    held = {resp_err, resp_rdata};
    for (int i = 0; i < stall; i++) begin
      if (poke && i == 1) begin
        req_valid = 1'b1; req_wren = 1'b1; req_addr = BASE;
        req_wdata = 32'hBAD0_BAD0; req_be = 4'hF;
      end
      @(negedge clk);
      clear_req();
      check("stall_resp_valid", 33'(resp_valid), 33'd1);
      check("stall_resp_stable", {resp_err, resp_rdata}, held);
      check("stall_req_ready", 33'(req_ready), 33'd0);
      check("stall_state", 33'(state_dbg), 33'd2);
    end
    resp_ready = 1'b1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got response %h, expected none", {resp_err, resp_rdata});
    end else begin
      want = exp_q.pop_front();
      check("resp_err_rdata", {resp_err, resp_rdata}, want);
    end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("resp_valid_cleared", 33'(resp_valid), 33'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  b;
    int          k;

    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_req_ready", 33'(req_ready), 33'd1);
    check("reset_resp_valid", 33'(resp_valid), 33'd0);
    check("reset_resp_rdata", 33'(resp_rdata), 33'd0);
    check("reset_resp_err", 33'(resp_err), 33'd0);
    check("reset_led_out", 33'(led_out), 33'd0);
    check("reset_state", 33'(state_dbg), 33'd0);
    rst = 1'b1;

    add_vec(1, BASE + 32'h0,   32'h1111_1111, 4'hF,    32'h0,          0);
    add_vec(1, BASE + 32'h4,   32'hDEAD_BEEF, 4'hF,    32'h0,          0);
    add_vec(0, BASE + 32'h4,   32'h0,         4'h0,    32'hDEAD_BEEF,  0);
    add_vec(1, BASE + 32'h4,   32'h0000_00AA, 4'b0001, 32'h0,          0);
    add_vec(0, BASE + 32'h4,   32'h0,         4'h0,    32'hDEAD_BEAA,  0);
    add_vec(1, BASE + 32'hFFC, 32'h1234_5678, 4'hF,    32'h0,          0);
    add_vec(0, BASE + 32'hFFC, 32'h0,         4'h0,    32'h1234_5678,  0);
    add_vec(0, BASE + 32'h2,   32'h0,         4'h0,    32'h0,          1);
    add_vec(0, BASE + 32'h1000, 32'h0,        4'h0,    32'h0,          1);
    add_vec(0, 32'h1000_FFFC,  32'h0,         4'h0,    32'h0,          1);
    add_vec(1, BASE + 32'h1000, 32'hFFFF_FFFF, 4'hF,   32'h0,          1);
    add_vec(1, BASE + 32'hFFE, 32'h0,         4'hF,    32'h0,          1);
    add_vec(1, 32'h1000_FFFC,  32'hFFFF_FFFF, 4'hF,    32'h0,          1);
    add_vec(0, BASE + 32'hFFC, 32'h0,         4'h0,    32'h1234_5678,  0);
    add_vec(0, BASE + 32'h0,   32'h0,         4'h0,    32'h1111_1111,  0);
    add_vec(1, BASE + 32'h4,   32'hFFFF_FFFF, 4'b0000, 32'h0,          0);
    add_vec(0, BASE + 32'h4,   32'h0,         4'h0,    32'hDEAD_BEAA,  0);
    add_vec(1, BASE + 32'h8,   32'hCAFE_0000, 4'b1100, 32'h0,          0);
    add_vec(1, BASE + 32'h8,   32'h0000_F00D, 4'b0011, 32'h0,          0);
    add_vec(0, BASE + 32'h8,   32'h0,         4'h0,    32'hCAFE_F00D,  0);

    foreach (vecs[i]) begin
      do_req(vecs[i].wren, vecs[i].addr, vecs[i].wdata, vecs[i].be,
             vecs[i].exp_rdata, vecs[i].exp_err, int'($urandom_range(0, 2)), 1'b0);
    end

    // Backpressure with an ignored store pulse to word 0 while in RESP.
    do_req(0, BASE + 32'h4, 32'h0, 4'h0, 32'hDEAD_BEAA, 0, 5, 1'b1);
    do_req(0, BASE + 32'h0, 32'h0, 4'h0, 32'h1111_1111, 0, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      model[i] = $urandom;
      do_req(1, BASE + 32'h100 + 32'(4 * i), model[i], 4'hF, 32'h0, 0, 0, 1'b0);
    end
    for (int n = 0; n < 24; n++) begin
      k = int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        b = 4'($urandom_range(0, 15));
        for (int j = 0; j < 4; j++) if (b[j]) model[k][8*j +: 8] = d[8*j +: 8];
        do_req(1, BASE + 32'h100 + 32'(4 * k), d, b, 32'h0, 0, int'($urandom_range(0, 1)), 1'b0);
      end else begin
        do_req(0, BASE + 32'h100 + 32'(4 * k), 32'h0, 4'h0, model[k], 0,
               int'($urandom_range(0, 1)), 1'b0);
      end
    end

`ifdef MMIO_LED_EN
    do_req(1, 32'hFFFF_0000, 32'h0000_03FF, 4'b0011, 32'h0, 0, 0, 1'b0);
    check("led_after_store", 33'(led_out), 33'h3FF);
    do_req(0, 32'hFFFF_0000, 32'h0, 4'h0, 32'h0000_03FF, 0, 0, 1'b0);
    do_req(1, 32'hFFFF_0000, 32'h0, 4'b0010, 32'h0, 0, 0, 1'b0);
    check("led_after_high_clear", 33'(led_out), 33'h0FF);
`else
    do_req(1, 32'hFFFF_0000, 32'h0000_03FF, 4'b0011, 32'h0, 1, 0, 1'b0);
    check("led_after_store", 33'(led_out), 33'h0);
    do_req(0, 32'hFFFF_0000, 32'h0, 4'h0, 32'h0, 1, 0, 1'b0);
`endif

    // Reset while a store response is pending: response dropped, store kept.
    @(negedge clk);
    req_valid = 1'b1; req_wren = 1'b1; req_addr = BASE + 32'h20;
    req_wdata = 32'h5A5A_5A5A; req_be = 4'hF;
    @(posedge clk); #1;
    clear_req();
    repeat (2) @(negedge clk);
    check("pre_reset_resp_valid", 33'(resp_valid), 33'd1);
    rst = 1'b0;
    #1;
    check("midreset_resp_valid", 33'(resp_valid), 33'd0);
    check("midreset_state", 33'(state_dbg), 33'd0);
    check("midreset_req_ready", 33'(req_ready), 33'd1);
    check("midreset_led_out", 33'(led_out), 33'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_resp_valid", 33'(resp_valid), 33'd0);
    do_req(0, BASE + 32'h20, 32'h0, 4'h0, 32'h5A5A_5A5A, 0, 0, 1'b0);

    check("scoreboard_drained", 33'(exp_q.size()), 33'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
